wash_phase_timer: RTL and testbench
===================================

Name: wash_phase_timer

Overview:
Programmable per-phase countdown timer that sits directly upstream of washing_machine_controller. The controller loads a phase duration in seconds and raises start. The block derives a 1-second tick from the system clock according to clk_freq, counts the duration down, and honours timer_pause. It returns a single-cycle done pulse that the controller uses to advance filling → washing → rinsing → spinning.

Parameters:
BASE_CYCLES, 1_000_000, clock cycles per second when clk_freq=2'b00 (1 MHz); the bench overrides it to 4
SEC_W, 9, width of the duration and remaining-seconds fields (max 511 s)
PRE_W, 24, prescaler width; must hold (BASE_CYCLES<<3)-1

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
clk_freq  input  2  clock-rate select: 00=1x, 01=2x, 10=4x, 11=8x BASE_CYCLES per second
start  input  1  one-cycle pulse: load duration_s and begin counting
duration_s  input  SEC_W  phase duration in seconds, sampled with start
abort  input  1  one-cycle pulse: cancel the current phase without done
timer_pause  input  1  level: freeze the countdown while high
done  output  1  one-cycle pulse when the countdown reaches 0
busy  output  1  high while state is RUN or PAUSED
paused  output  1  high while state is PAUSED
sec_tick  output  1  one-cycle pulse at each decrement of the seconds count
remaining_s  output  SEC_W  seconds left in the current phase

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous and active-low. While rst_n=0, every register and output is 0 and state=IDLE, including mid-run.
- States: IDLE, RUN, PAUSED.
- IDLE→RUN: start with duration_s≠0.
- RUN→PAUSED: timer_pause=1.
- PAUSED→RUN: timer_pause=0.
- RUN→IDLE: terminal tick when remaining_s=1.
- RUN/PAUSED→IDLE: abort.
- Load:
  - Sample on start: duration_s→remaining_s; clk_freq→freq_q (latched); prescaler cleared to 0.
  - N = BASE_CYCLES << freq_q.
  - A clk_freq change while busy has no effect until the next start.
- Count enable: en = (state==RUN) && !timer_pause, evaluated combinationally. A pause therefore freezes the count in the same cycle it is asserted.
- Prescaler:
  - When en=1, the prescaler increments.
  - At N-1 it wraps to 0, pulses sec_tick and decrements remaining_s.
  - While paused, the prescaler holds its value. Resume continues from that value; no restart of the partial second.
- Done:
  - On the tick that takes remaining_s from 1 to 0: done=1 for exactly one cycle and state→IDLE.
  - Latency: start sampled at edge k with no pause ⇒ done high during the cycle after edge k+D·N.
  - Every paused cycle adds exactly one cycle to that latency.
- Zero duration: start with duration_s=0 ⇒ done pulses the next cycle; busy stays 0.
- Start while busy: reload and restart (prescaler 0, new freq_q). State goes to RUN, or PAUSED if timer_pause=1. No done for the abandoned phase.
- Priorities: abort wins over start and over a same-cycle terminal tick. In that case there is no done, and remaining_s and the prescaler clear to 0.
- IDLE behaviour: timer_pause and abort are ignored; remaining_s holds 0.
- Output timing: outputs are registered or decoded directly from state; done, sec_tick and remaining_s are registered.

Decomposition:
- Package wm_pkg:
  - clk_freq encodings.
  - Timer state encoding (IDLE=2'b00, RUN=2'b01, PAUSED=2'b10).
  - Phase duration constants FILL_S=60, WASH_S=300, RINSE_S=120, SPIN_S=60. The controller reuses these when driving duration_s.
- Sub-module wm_sec_prescaler: enable/clear/freq_q in, sec_tick out, holding the PRE_W counter and N selection. The FSM and seconds counter stay in wash_phase_timer.

Test Plan:
- Basic run (BASE_CYCLES=4, clk_freq=00): start, duration_s=3 → remaining_s steps 3,2,1,0 every 4 cycles; three sec_ticks; done pulses once, 12 cycles after the start edge; busy falls with done.
- Frequency latch (clk_freq=11, duration_s=2): N=32, so done comes 64 cycles after start. Switching clk_freq to 00 at cycle 10 must not change the timing.
- Pause: duration_s=2, clk_freq=00, timer_pause high for 10 cycles starting at cycle 3 → paused=1 for those cycles, remaining_s frozen, done delayed to cycle 18.
- Abort and priority:
  - Abort at cycle 5 of a 3 s run → busy=0 and remaining_s=0 next cycle; no done ever.
  - start and abort in the same cycle → stays IDLE.
- Zero duration and restart:
  - duration_s=0 → done one cycle after start; busy never 1.
  - start with 5 mid-run of a 3 s phase → remaining_s=5; done only after the full 5·N cycles.
- Reset mid-run: rst_n low at cycle 6 → all outputs 0 immediately (asynchronous). After release, a new start of 1 s gives done 4 cycles later.

Source files
------------

// File: rtl/wm_pkg.sv
// rtl/wm_pkg.sv - shared encodings and phase constants for the wash timer and controller
package wm_pkg;

    typedef enum logic [1:0] {
        FREQ_1X = 2'b00,
        FREQ_2X = 2'b01,
        FREQ_4X = 2'b10,
        FREQ_8X = 2'b11
    } clk_freq_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_RUN    = 2'b01,
        ST_PAUSED = 2'b10
    } timer_state_e;

    localparam int unsigned FILL_S  = 60;
    localparam int unsigned WASH_S  = 300;
    localparam int unsigned RINSE_S = 120;
    localparam int unsigned SPIN_S  = 60;

    // Clock cycles in one second for a given rate select.
    function automatic logic [31:0] sec_period(input int unsigned base, input logic [1:0] freq);
        return 32'(base) << freq;
    endfunction

endpackage

// File: rtl/wm_sec_prescaler.sv
// rtl/wm_sec_prescaler.sv - divides clk down to a one-second tick for the latched rate select
module wm_sec_prescaler
    import wm_pkg::*;
#(
    parameter int unsigned BASE_CYCLES = 1_000_000,
    parameter int unsigned PRE_W       = 24
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_en,
    input  logic       i_clr,
    input  logic [1:0] i_freq_q,
    output logic       o_tick
);

    logic [PRE_W-1:0] r_count;
    logic [PRE_W-1:0] w_last;

    assign w_last = PRE_W'(sec_period(BASE_CYCLES, i_freq_q) - 32'd1);
    assign o_tick = i_en && (r_count == w_last);

    // Count holds while disabled so a resumed phase keeps its partial second.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (i_clr || o_tick) begin
            r_count <= '0;
        end else if (i_en) begin
            r_count <= r_count + 1'b1;
        end
    end

endmodule

// File: rtl/wash_phase_timer.sv
// rtl/wash_phase_timer.sv - per-phase seconds countdown with pause, abort and a one-cycle done pulse
module wash_phase_timer
    import wm_pkg::*;
#(
    parameter int unsigned BASE_CYCLES = 1_000_000,
    parameter int unsigned SEC_W       = 9,
    parameter int unsigned PRE_W       = 24
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [1:0]       clk_freq,
    input  logic             start,
    input  logic [SEC_W-1:0] duration_s,
    input  logic             abort,
    input  logic             timer_pause,
    output logic             done,
    output logic             busy,
    output logic             paused,
    output logic             sec_tick,
    output logic [SEC_W-1:0] remaining_s
);

    timer_state_e     r_state;
    timer_state_e     w_state_nxt;
    logic [1:0]       r_freq_q;
    logic [SEC_W-1:0] r_remaining;
    logic             r_done;
    logic             r_sec_tick;
    logic             w_busy;
    logic             w_en;
    logic             w_clr;
    logic             w_wrap;
    logic             w_terminal;

    assign w_busy     = (r_state != ST_IDLE);
    // A released pause counts in the same cycle, so each paused cycle costs exactly one cycle.
    assign w_en       = w_busy && !timer_pause && !abort && !start;
    assign w_clr      = abort || start;
    assign w_terminal = w_wrap && (r_remaining == SEC_W'(1));

    wm_sec_prescaler #(
        .BASE_CYCLES (BASE_CYCLES),
        .PRE_W       (PRE_W)
    ) u_prescaler (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_en     (w_en),
        .i_clr    (w_clr),
        .i_freq_q (r_freq_q),
        .o_tick   (w_wrap)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (abort) begin
            w_state_nxt = ST_IDLE;
        end else if (start) begin
            if (duration_s == '0) begin
                w_state_nxt = ST_IDLE;
            end else if (w_busy && timer_pause) begin
                w_state_nxt = ST_PAUSED;
            end else begin
                w_state_nxt = ST_RUN;
            end
        end else if (w_terminal) begin
            w_state_nxt = ST_IDLE;
        end else if (w_busy) begin
            w_state_nxt = timer_pause ? ST_PAUSED : ST_RUN;
        end
    end

    always_comb begin
        busy        = w_busy;
        paused      = (r_state == ST_PAUSED);
        done        = r_done;
        sec_tick    = r_sec_tick;
        remaining_s = r_remaining;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_remaining <= '0;
            r_freq_q    <= '0;
            r_done      <= 1'b0;
            r_sec_tick  <= 1'b0;
        end else begin
            r_done     <= 1'b0;
            r_sec_tick <= 1'b0;
            if (abort) begin
                r_remaining <= '0;
            end else if (start) begin
                r_remaining <= duration_s;
                r_freq_q    <= clk_freq;
                r_done      <= (duration_s == '0);
            end else if (w_wrap) begin
                r_remaining <= r_remaining - SEC_W'(1);
                r_sec_tick  <= 1'b1;
                r_done      <= w_terminal;
            end
        end
    end

endmodule

// File: tb/tb_wash_phase_timer.sv
// tb/tb_wash_phase_timer.sv - randomized scoreboard bench for wash_phase_timer
module tb_wash_phase_timer;

    localparam int unsigned BASE  = 4;
    localparam int unsigned SEC_W = 9;

    logic             clk;
    logic             rst_n;
    logic [1:0]       clk_freq;
    logic             start;
    logic [SEC_W-1:0] duration_s;
    logic             abort;
    logic             timer_pause;
    logic             done;
    logic             busy;
    logic             paused;
    logic             sec_tick;
    logic [SEC_W-1:0] remaining_s;

    wash_phase_timer #(.BASE_CYCLES(BASE), .SEC_W(SEC_W), .PRE_W(24)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .clk_freq    (clk_freq),
        .start       (start),
        .duration_s  (duration_s),
        .abort       (abort),
        .timer_pause (timer_pause),
        .done        (done),
        .busy        (busy),
        .paused      (paused),
        .sec_tick    (sec_tick),
        .remaining_s (remaining_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic             b;
        logic             p;
        logic [SEC_W-1:0] r;
    } snap_t;

    snap_t exp_q[$];
    int    done_q[$];
    int    tick_cyc_q[$];
    int    tick_rem_q[$];

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    // Reference model: phase progress measured in counted cycles within the current second.
    bit m_busy, m_paused;
    int m_rem, m_phase, m_n;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        m_busy = 0; m_paused = 0; m_rem = 0; m_phase = 0; m_n = BASE;
    endtask

    // Called at a negedge: apply inputs, predict the following edge, push expectations.
    task automatic drv(input bit st, input int dur, input int fr, input bit ab, input bit pz);
        int nxt;
        snap_t s;
        nxt         = cyc + 1;
        start       = st;
        duration_s  = SEC_W'(dur);
        clk_freq    = 2'(fr);
        abort       = ab;
        timer_pause = pz;
        if (ab) begin
            m_busy = 0; m_paused = 0; m_rem = 0; m_phase = 0;
        end else if (st) begin
            if (dur == 0) begin
                m_busy = 0; m_paused = 0; m_rem = 0;
                done_q.push_back(nxt);
            end else begin
                m_paused = m_busy && pz;
                m_busy   = 1;
                m_rem    = dur;
                m_phase  = 0;
                m_n      = BASE * (1 << fr);
            end
        end else if (m_busy) begin
            m_paused = pz;
            if (!pz) begin
                m_phase++;
                if (m_phase == m_n) begin
                    m_phase = 0;
                    m_rem--;
                    tick_cyc_q.push_back(nxt);
                    tick_rem_q.push_back(m_rem);
                    if (m_rem == 0) begin
                        m_busy = 0; m_paused = 0;
                        done_q.push_back(nxt);
                    end
                end
            end
        end
        s.b = m_busy; s.p = m_paused; s.r = SEC_W'(m_rem);
        exp_q.push_back(s);
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drv(0, 0, 0, 0, 0);
    endtask

    always @(posedge clk) begin
        #1;
        if (rst_n) begin
            snap_t e;
            cyc++;
            if (exp_q.size() == 0) begin
                chk("exp_queue_empty", 1, 0);
            end else begin
                e = exp_q.pop_front();
                chk("busy", int'(busy), int'(e.b));
                chk("paused", int'(paused), int'(e.p));
                chk("remaining_s", int'(remaining_s), int'(e.r));
            end
            if (done) begin
                if (done_q.size() == 0) chk("unexpected_done", cyc, -1);
                else chk("done_cycle", cyc, done_q.pop_front());
            end
            if (sec_tick) begin
                if (tick_cyc_q.size() == 0) begin
                    chk("unexpected_tick", cyc, -1);
                end else begin
                    chk("tick_cycle", cyc, tick_cyc_q.pop_front());
                    chk("tick_remaining", int'(remaining_s), tick_rem_q.pop_front());
                end
            end
        end
    end

    initial begin
        bit pz;
        rst_n = 1'b0; start = 0; duration_s = '0; clk_freq = '0; abort = 0; timer_pause = 0;
        model_reset();
        repeat (3) @(negedge clk);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_remaining", int'(remaining_s), 0);
        rst_n = 1'b1;

        // basic run, then frequency latch with a mid-run rate change
        drv(1, 3, 0, 0, 0); idle(14);
        drv(1, 2, 3, 0, 0); for (int i = 0; i < 9; i++) drv(0, 0, 3, 0, 0); idle(60);
        // pause for ten cycles
        drv(1, 2, 0, 0, 0); idle(2);
        for (int i = 0; i < 10; i++) drv(0, 0, 0, 0, 1);
        idle(10);
        // abort mid-run, then start+abort together
        drv(1, 3, 0, 0, 0); idle(4); drv(0, 0, 0, 1, 0); idle(15);
        drv(1, 3, 0, 1, 0); idle(3);
        // zero duration, then restart mid-run
        drv(1, 0, 0, 0, 0); idle(3);
        drv(1, 3, 0, 0, 0); idle(5); drv(1, 5, 0, 0, 0); idle(25);
        // asynchronous reset mid-run
        drv(1, 3, 0, 0, 0); idle(5);
        rst_n = 1'b0;
        #1;
        chk("async_rst_busy", int'(busy), 0);
        chk("async_rst_remaining", int'(remaining_s), 0);
        chk("async_rst_tick", int'(sec_tick), 0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        drv(1, 1, 0, 0, 0); idle(6);

        // random traffic
        pz = 0;
        for (int i = 0; i < 3000; i++) begin
            bit st, ab;
            if ($urandom_range(0, 24) == 0) pz = !pz;
            st = m_busy ? ($urandom_range(0, 299) == 0) : ($urandom_range(0, 7) == 0);
            ab = ($urandom_range(0, 199) == 0);
            drv(st, int'($urandom_range(0, 5)), int'($urandom_range(0, 3)), ab, pz);
        end
        drv(0, 0, 0, 1, 0); idle(3);

        chk("leftover_done", done_q.size(), 0);
        chk("leftover_tick", tick_cyc_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
